// File: rtl/sushi_scorer.sv
// Catch-to-score game logic: decodes caught objects into BCD points, strikes and a combo
// multiplier, feeding the HUD. Points are added one BCD unit per cycle while in ADD.

// One BCD digit of the score incrementer; carries ripple digit to digit.
module sushi_bcd_digit (
  input  logic [3:0] i_d,
  input  logic       i_cin,
  output logic [3:0] o_q,
  output logic       o_cout
);
  logic w_nine;

  assign w_nine = (i_d == 4'd9);
  assign o_cout = i_cin & w_nine;
  assign o_q    = !i_cin ? i_d : (w_nine ? 4'd0 : i_d + 4'd1);
endmodule

module sushi_scorer #(
  parameter int MAX_STRIKES = 3,
  parameter int COMBO_LEN   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_catch_valid,
  input  logic [1:0]  i_obj_code,
  output logic        o_ready,
  output logic [15:0] o_score_bcd,
  output logic [1:0]  o_strikes,
  output logic        o_combo,
  output logic        o_game_over
);
  localparam int NUM_DIGITS = 4;
  localparam int SW = $clog2(COMBO_LEN + 1);
  localparam logic [SW-1:0] COMBO_V = SW'(COMBO_LEN);
  localparam logic [1:0]    MAX_V   = 2'(MAX_STRIKES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_ADD, S_OVER} state_t;

  state_t        r_state, w_state_n;
  logic [15:0]   r_score, w_score_n, w_score_inc;
  logic [1:0]    r_strikes, w_strikes_n, w_strikes_inc;
  logic [SW-1:0] r_streak, w_streak_n, w_streak_inc;
  logic [2:0]    r_pending, w_pending_n;
  logic [NUM_DIGITS:0] w_carry;

  // Carry out of the top digit with a forced carry-in means every digit is 9: the score is saturated.
  assign w_carry[0] = 1'b1;
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      sushi_bcd_digit u_dig (
        .i_d    (r_score[4*g +: 4]),
        .i_cin  (w_carry[g]),
        .o_q    (w_score_inc[4*g +: 4]),
        .o_cout (w_carry[g+1])
      );
    end
  endgenerate

  assign w_strikes_inc = r_strikes + 2'd1;
  assign w_streak_inc  = (r_streak == COMBO_V) ? COMBO_V : r_streak + SW'(1);

  always_comb begin
    w_state_n   = r_state;
    w_score_n   = r_score;
    w_strikes_n = r_strikes;
    w_streak_n  = r_streak;
    w_pending_n = r_pending;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          w_score_n   = '0;
          w_strikes_n = '0;
          w_streak_n  = '0;
          w_pending_n = '0;
          w_state_n   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (i_catch_valid) begin
          if (i_obj_code == 2'b00) begin
            w_streak_n  = '0;
            w_strikes_n = w_strikes_inc;
            if (w_strikes_inc == MAX_V) w_state_n = S_OVER;
          end else begin
            w_streak_n  = w_streak_inc;
            w_pending_n = (w_streak_inc == COMBO_V) ? {i_obj_code, 1'b0} : {1'b0, i_obj_code};
            w_state_n   = S_ADD;
          end
        end
      end
      S_ADD: begin
        if (!w_carry[NUM_DIGITS]) w_score_n = w_score_inc;
        w_pending_n = r_pending - 3'd1;
        if (r_pending == 3'd1) w_state_n = S_PLAY;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_score   <= '0;
      r_strikes <= '0;
      r_streak  <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_n;
      r_score   <= w_score_n;
      r_strikes <= w_strikes_n;
      r_streak  <= w_streak_n;
      r_pending <= w_pending_n;
    end
  end

  assign o_ready     = (r_state == S_PLAY);
  assign o_game_over = (r_state == S_OVER);
  assign o_combo     = (r_streak == COMBO_V);
  assign o_score_bcd = r_score;
  assign o_strikes   = r_strikes;
endmodule

// File: tb/tb_sushi_scorer.sv
// Bench for sushi_scorer: directed scenarios plus a randomized run against an integer-score game model.
module tb_sushi_scorer;
  localparam int MAXS = 3;
  localparam int CL   = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_ADD = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, cv = 1'b0;
  logic [1:0]  code = 2'b00;
  logic        o_ready, o_combo, o_game_over;
  logic [15:0] o_score_bcd;
  logic [1:0]  o_strikes;

  int errors = 0;
  int checks = 0;

  // game model: integer score and plain counters
  int m_mode = M_IDLE, m_score = 0, m_strikes = 0, m_streak = 0, m_pend = 0;

  sushi_scorer #(.MAX_STRIKES(MAXS), .COMBO_LEN(CL)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_catch_valid(cv), .i_obj_code(code),
    .o_ready(o_ready), .o_score_bcd(o_score_bcd), .o_strikes(o_strikes),
    .o_combo(o_combo), .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_score = 0; m_strikes = 0; m_streak = 0; m_pend = 0;
    end else if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (start) begin m_mode = M_PLAY; m_score = 0; m_strikes = 0; m_streak = 0; end
    end else if (m_mode == M_PLAY) begin
      if (cv && code == 2'b00) begin
        m_streak = 0; m_strikes++;
        if (m_strikes == MAXS) m_mode = M_OVER;
      end else if (cv) begin
        m_streak = (m_streak + 1 > CL) ? CL : m_streak + 1;
        m_pend = int'(code) * ((m_streak == CL) ? 2 : 1);
        m_mode = M_ADD;
      end
    end else begin
      if (m_score < 9999) m_score++;
      m_pend--;
      if (m_pend == 0) m_mode = M_PLAY;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_wasabi();
    cv = 1'b1; code = 2'b00; tick(); cv = 1'b0;
  endtask

  // Issue one sushi catch and wait (bounded) for ready; reports the ADD length.
  task automatic do_catch(input logic [1:0] c, output int addc);
    cv = 1'b1; code = c; tick(); cv = 1'b0;
    addc = 0;
    while (!o_ready && !o_game_over && addc < 20) begin tick(); addc++; end
    if (addc >= 20) begin
      errors++; $display("FAIL catch_timeout ready never returned after %0d cycles", addc);
    end
    checks++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_ready, o_game_over, o_combo, o_strikes, o_score_bcd} !== {3'b000, 2'd0, 16'h0000}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h",
        {o_ready, o_game_over, o_combo, o_strikes, o_score_bcd}, 21'h0);
    end
  endtask

  task automatic test_single();
    do_reset(); do_start();
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL start_ready got=%b exp=1", o_ready); end
    cv = 1'b1; code = 2'b01; tick(); cv = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_score_bcd !== 16'h0000) begin
      errors++; $display("FAIL single_add ready=%b score=%h exp ready=0 score=0000", o_ready, o_score_bcd);
    end
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_score_bcd !== 16'h0001 || o_strikes !== 2'd0) begin
      errors++; $display("FAIL single_done ready=%b score=%h strikes=%0d exp 1/0001/0",
        o_ready, o_score_bcd, o_strikes);
    end
  endtask

  task automatic test_combo();
    logic [15:0] exp_s [4];
    int          exp_c [4];
    int addc;
    exp_s[0] = 16'h0003; exp_s[1] = 16'h0006; exp_s[2] = 16'h0009; exp_s[3] = 16'h0015;
    exp_c[0] = 3; exp_c[1] = 3; exp_c[2] = 3; exp_c[3] = 6;
    do_reset(); do_start();
    for (int i = 0; i < 4; i++) begin
      do_catch(2'b11, addc);
      checks++;
      if (o_score_bcd !== exp_s[i] || addc != exp_c[i] || o_combo !== (i == 3)) begin
        errors++; $display("FAIL combo_%0d score=%h add=%0d combo=%b exp %h/%0d/%b",
          i, o_score_bcd, addc, o_combo, exp_s[i], exp_c[i], (i == 3));
      end
    end
  endtask

  task automatic test_carry();
    int addc;
    do_reset(); do_start();
    do_catch(2'b11, addc); do_catch(2'b11, addc); do_catch(2'b10, addc);
    repeat (15) do_catch(2'b11, addc);
    checks++;
    if (o_score_bcd !== 16'h0098) begin
      errors++; $display("FAIL carry_pre score=%h exp=0098", o_score_bcd);
    end
    do_wasabi();
    cv = 1'b1; code = 2'b10; tick(); cv = 1'b0;
    tick();
    checks++;
    if (o_score_bcd !== 16'h0099) begin errors++; $display("FAIL carry_99 score=%h exp=0099", o_score_bcd); end
    tick();
    checks++;
    if (o_score_bcd !== 16'h0100 || o_ready !== 1'b1) begin
      errors++; $display("FAIL carry_100 score=%h ready=%b exp=0100/1", o_score_bcd, o_ready);
    end
  endtask

  task automatic test_strikes();
    int addc;
    do_reset(); do_start();
    do_catch(2'b01, addc);
    for (int i = 1; i <= 3; i++) begin
      do_wasabi();
      checks++;
      if (o_strikes !== 2'(i) || o_game_over !== (i == 3) || o_ready !== (i != 3)) begin
        errors++; $display("FAIL strike_%0d strikes=%0d over=%b ready=%b", i, o_strikes, o_game_over, o_ready);
      end
    end
    cv = 1'b1; code = 2'b11; tick(); cv = 1'b0; tick();
    checks++;
    if (o_score_bcd !== 16'h0001 || o_strikes !== 2'd3 || o_game_over !== 1'b1) begin
      errors++; $display("FAIL over_hold score=%h strikes=%0d over=%b exp 0001/3/1",
        o_score_bcd, o_strikes, o_game_over);
    end
    do_start();
    checks++;
    if (o_ready !== 1'b1 || o_score_bcd !== 16'h0000 || o_strikes !== 2'd0 || o_game_over !== 1'b0) begin
      errors++; $display("FAIL restart ready=%b score=%h strikes=%0d over=%b",
        o_ready, o_score_bcd, o_strikes, o_game_over);
    end
  endtask

  task automatic test_saturate();
    int addc;
    do_reset(); do_start();
    do_catch(2'b11, addc); do_catch(2'b11, addc); do_catch(2'b10, addc);
    repeat (1665) do_catch(2'b11, addc);
    checks++;
    if (o_score_bcd !== 16'h9998) begin errors++; $display("FAIL sat_pre score=%h exp=9998", o_score_bcd); end
    do_wasabi();
    cv = 1'b1; code = 2'b11; tick(); cv = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_score_bcd !== 16'h9999 || o_ready !== (i == 3)) begin
        errors++; $display("FAIL sat_%0d score=%h ready=%b exp 9999/%b", i, o_score_bcd, o_ready, (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid_add();
    int addc;
    do_reset(); do_start();
    repeat (4) do_catch(2'b11, addc);
    cv = 1'b1; code = 2'b11; tick(); cv = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({o_ready, o_game_over, o_combo, o_strikes, o_score_bcd} !== 21'h0) begin
      errors++; $display("FAIL mid_add_reset got=%h exp=000000", {o_ready, o_game_over, o_combo, o_strikes, o_score_bcd});
    end
    cv = 1'b1; code = 2'b11; tick(); cv = 1'b0; tick();
    checks++;
    if (o_ready !== 1'b0 || o_score_bcd !== 16'h0000) begin
      errors++; $display("FAIL idle_drop ready=%b score=%h exp 0/0000", o_ready, o_score_bcd);
    end
    start = 1'b1; cv = 1'b1; code = 2'b11; tick(); start = 1'b0; cv = 1'b0; tick();
    checks++;
    if (o_ready !== 1'b1 || o_score_bcd !== 16'h0000) begin
      errors++; $display("FAIL start_wins ready=%b score=%h exp 1/0000", o_ready, o_score_bcd);
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v, got_v;
    do_reset(); do_start();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 19) == 0);
      cv    = $urandom_range(0, 1);
      code  = 2'($urandom_range(0, 3));
      tick();
      exp_v = {m_mode == M_PLAY, m_mode == M_OVER, m_streak == CL, 2'(m_strikes), to_bcd(m_score)};
      got_v = {o_ready, o_game_over, o_combo, o_strikes, o_score_bcd};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL random_cyc%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
    rst = 1'b0; start = 1'b0; cv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_combo();
    test_carry();
    test_strikes();
    test_saturate();
    test_reset_mid_add();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
